// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Asynchronous serial transmitter. Takes one parallel word per valid/ready
// handshake and serialises it as a frame:
//   start (0), data MSB first, optional parity, stop bit(s) (1).
// Every bit slot lasts BIT = 2*p_BITSLOT_HALF_PERIOD clock cycles. The frame
// format matches the companion receiver built with the same parameters.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         asynchronous reset, active-high
//   iv_data       word to send, sampled only on accept
//   i_data_valid  source offers iv_data
//   o_ready       transmitter idle and able to accept
//   o_output      serial line, idle high, registered
//   o_busy        frame in progress (complement of o_ready outside reset)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int p_BITSLOT_HALF_PERIOD = 1,
    parameter int p_DATA_BITS           = 8,
    parameter int p_STOP_BITS           = 1,
    parameter int p_PARITY              = 1,
    parameter int p_PARITY_ODD          = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [p_DATA_BITS-1:0] iv_data,
    input  logic                   i_data_valid,
    output logic                   o_ready,
    output logic                   o_output,
    output logic                   o_busy
);

    localparam int BIT     = 2 * p_BITSLOT_HALF_PERIOD;
    localparam int DLY_W   = ($clog2(BIT) > 1) ? $clog2(BIT) : 1;
    localparam int REP_MAX = (p_DATA_BITS > p_STOP_BITS) ? p_DATA_BITS : p_STOP_BITS;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    localparam logic [DLY_W-1:0] DLY_RELOAD    = DLY_W'(BIT - 1);
    localparam logic [REP_W-1:0] REP_DATA_LAST = REP_W'(p_DATA_BITS - 1);
    localparam logic [REP_W-1:0] REP_STOP_LAST = REP_W'(p_STOP_BITS - 1);
    localparam logic             PAR_ODD       = (p_PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam bit               HAS_PARITY    = (p_PARITY != 0);

    if (p_BITSLOT_HALF_PERIOD < 1 || p_DATA_BITS < 1 || p_STOP_BITS < 1) begin : g_param_check
        $error("uart_tx: p_BITSLOT_HALF_PERIOD, p_DATA_BITS and p_STOP_BITS must all be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic                   out_q, out_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [p_DATA_BITS-1:0] shift_q, shift_d;
    logic                   par_q, par_d;
    logic [p_DATA_BITS-1:0] shifted;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        rep_d   = rep_q;
        out_d   = out_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        shift_d = shift_q;
        par_d   = par_q;
        shifted = shift_q << 1;

        if (state_q == S_IDLE) begin
            // ready_q is always high in IDLE, so valid alone means accept.
            // The line drops on this same edge: first low cycle follows accept.
            if (i_data_valid) begin
                state_d = S_START;
                shift_d = iv_data;
                par_d   = (^iv_data) ^ PAR_ODD;
                out_d   = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b1;
                dly_d   = DLY_RELOAD;
                rep_d   = '0;
            end
        end else if (dly_q != '0) begin
            dly_d = dly_q - 1'b1;
        end else begin
            // Slot boundary: the next slot's line value is registered here so
            // that every slot is exactly BIT cycles long.
            dly_d = DLY_RELOAD;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    rep_d   = '0;
                    out_d   = shift_q[p_DATA_BITS-1];
                end
                S_DATA: begin
                    if (rep_q == REP_DATA_LAST) begin
                        rep_d = '0;
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            out_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        rep_d   = rep_q + 1'b1;
                        shift_d = shifted;
                        out_d   = shifted[p_DATA_BITS-1];
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                    rep_d   = '0;
                    out_d   = 1'b1;
                end
                S_STOP: begin
                    if (rep_q == REP_STOP_LAST) begin
                        state_d = S_IDLE;
                        rep_d   = '0;
                        dly_d   = '0;
                        out_d   = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rep_d   = '0;
                    dly_d   = '0;
                    out_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Control state: reset aborts any frame and returns the line high at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            rep_q   <= '0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            rep_q   <= rep_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Datapath: only meaningful after an accept, so it carries no reset.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign o_output = out_q;
    assign o_ready  = ready_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Five transmitter instances with different frame formats share one clock and
// reset. A frame model built from the frame rules predicts the line level for
// every cycle, and a mid-bit sampling receiver decodes each line back into
// words.
//   inst 0: half 2, parity odd,  1 stop
//   inst 1: half 2, parity even, 1 stop
//   inst 2: half 2, no parity,   2 stop
//   inst 3: half 1, parity odd,  1 stop
//   inst 4: half 3, parity even, 2 stop
// ---------------------------------------------------------------------------
module tb_uart_tx;

    function automatic int half_of(input int k);
        case (k)
            3:       return 1;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int par_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic int odd_of(input int k);
        return (k == 1 || k == 4) ? 0 : 1;
    endfunction

    function automatic int stop_of(input int k);
        return (k == 2 || k == 4) ? 2 : 1;
    endfunction

    logic       clk;
    logic       rst;
    logic       vld   [5];
    logic [7:0] dat   [5];
    logic       rdy_w [5];
    logic       out_w [5];
    logic       bsy_w [5];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        uart_tx #(
            .p_BITSLOT_HALF_PERIOD(half_of(g)),
            .p_DATA_BITS          (8),
            .p_STOP_BITS          (stop_of(g)),
            .p_PARITY             (par_of(g)),
            .p_PARITY_ODD         (odd_of(g))
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .iv_data     (dat[g]),
            .i_data_valid(vld[g]),
            .o_ready     (rdy_w[g]),
            .o_output    (out_w[g]),
            .o_busy      (bsy_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Accept monitor for instance 0 (back-to-back spacing).
    int cyc      = 0;
    int acc_last = 0;
    int acc_prev = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && rdy_w[0] && vld[0]) begin
            acc_prev = acc_last;
            acc_last = cyc;
        end
    end

    // Behavioural receiver: detect the falling start edge, sample each slot in
    // its middle, decode once the last stop bit has been sampled.
    bit          rx_act  [5];
    int          rx_cnt  [5];
    logic [15:0] rx_bits [5];
    logic [7:0]  rx_last [5];
    int          rx_n    [5];

    initial begin
        for (int k = 0; k < 5; k++) begin
            rx_act[k]  = 0;
            rx_cnt[k]  = 0;
            rx_bits[k] = '0;
            rx_last[k] = '0;
            rx_n[k]    = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rst) begin
                rx_act[k] = 0;
            end else if (!rx_act[k]) begin
                if (out_w[k] == 1'b0) begin
                    rx_act[k] = 1;
                    rx_cnt[k] = 0;
                end
            end else begin
                int bt;
                int nslots;
                int slot;
                bt     = 2 * half_of(k);
                nslots = 1 + 8 + par_of(k) + stop_of(k);
                rx_cnt[k] = rx_cnt[k] + 1;
                slot   = rx_cnt[k] / bt;
                if (rx_cnt[k] % bt == half_of(k)) begin
                    rx_bits[k][slot] = out_w[k];
                    if (slot == nslots - 1) begin
                        logic [7:0] d;
                        int ones;
                        for (int i = 0; i < 8; i++) d[7-i] = rx_bits[k][1+i];
                        check_eq("rx_start", rx_bits[k][0], 1'b0);
                        if (par_of(k) != 0) begin
                            ones = $countones(d) + int'(rx_bits[k][9]);
                            check_eq("rx_parity", ones % 2, odd_of(k));
                        end
                        for (int s = 0; s < stop_of(k); s++)
                            check_eq("rx_stop", rx_bits[k][9+par_of(k)+s], 1'b1);
                        rx_last[k] = d;
                        rx_n[k]    = rx_n[k] + 1;
                        rx_act[k]  = 0;
                    end
                end
            end
        end
    end

    // Called right after the accepting edge. Checks the line and handshake
    // every cycle of the frame, then the idle cycle and the decoded word.
    task automatic check_frame(input int k, input logic [7:0] w, input bit hold,
                               input logic [7:0] nxt);
        logic fb [16];
        int   n;
        int   bt;
        int   n0;
        int   ones;
        bt   = 2 * half_of(k);
        n0   = rx_n[k];
        ones = $countones(w);
        n = 0;
        fb[n] = 1'b0; n++;
        for (int i = 7; i >= 0; i--) begin fb[n] = w[i]; n++; end
        if (par_of(k) != 0) begin
            fb[n] = (odd_of(k) != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
            n++;
        end
        for (int s = 0; s < stop_of(k); s++) begin fb[n] = 1'b1; n++; end

        for (int c = 0; c < n * bt; c++) begin
            @(negedge clk);
            check_eq("line", out_w[k], fb[c / bt]);
            check_eq("rdy_busy_frame", {rdy_w[k], bsy_w[k]}, 2'b01);
            if (c == 0) begin
                dat[k] = nxt;
                if (!hold) vld[k] = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("idle_line", out_w[k], 1'b1);
        check_eq("rdy_busy_idle", {rdy_w[k], bsy_w[k]}, 2'b10);
        check_eq("rx_count", rx_n[k] - n0, 1);
        check_eq("rx_data", rx_last[k], w);
    endtask

    task automatic send(input int k, input logic [7:0] w);
        int t;
        t = 0;
        while (!rdy_w[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", rdy_w[k], 1'b1);
        if (rdy_w[k]) begin
            dat[k] = w;
            vld[k] = 1'b1;
            @(posedge clk);
            check_frame(k, w, 1'b0, 8'($urandom));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vld[k] = 1'b0;
            dat[k] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check_eq("reset_line", out_w[k], 1'b1);
            check_eq("reset_rdy_busy", {rdy_w[k], bsy_w[k]}, 2'b10);
        end
        #2 rst = 1'b0;

        // Known frames
        send(0, 8'hA5);
        send(0, 8'h07);
        send(1, 8'h07);
        send(2, 8'h00);
        for (int i = 0; i < 4; i++) begin
            send(0, 8'($urandom));
            send(1, 8'($urandom));
            send(2, 8'($urandom));
        end

        // Reset in the middle of a start bit
        n0 = rx_n[0];
        dat[0] = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        check_eq("pre_reset_line", out_w[0], 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("async_reset_line", out_w[0], 1'b1);
        check_eq("async_reset_rdy_busy", {rdy_w[0], bsy_w[0]}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("post_reset_line", out_w[0], 1'b1);
            check_eq("post_reset_rdy", rdy_w[0], 1'b1);
        end
        check_eq("post_reset_rx", rx_n[0] - n0, 0);

        // Back-to-back with valid held; data changes mid-frame
        dat[0] = 8'h55;
        vld[0] = 1'b1;
        @(posedge clk);
        check_frame(0, 8'h55, 1'b1, 8'hAA);
        @(posedge clk);
        check_frame(0, 8'hAA, 1'b0, 8'($urandom));
        check_eq("b2b_gap", acc_last - acc_prev, 45);

        // Loopback runs at half periods 1 and 3
        for (int i = 0; i < 256; i++) send(3, 8'($urandom));
        for (int i = 0; i < 256; i++) send(4, 8'($urandom));
        check_eq("loop3_count", rx_n[3], 256);
        check_eq("loop4_count", rx_n[4], 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
